alu_multicycle: RTL
===================

# alu_multicycle

Parametrised successor to the single-cycle RV32I integer ALU: a handshake-driven execution unit with a full RV32I register-register operation set, including SUB/SRA selected by the funct7 alternate bit and signed SLT. Shifts run iteratively through a narrow shifter, SHIFT_STEP bits per cycle, to keep area low. It sits between the decode/register-read stage and writeback. Each accepted operation produces exactly one result, which is held until the consumer takes it.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHIFT_STEP, 1, maximum bits shifted per cycle; must be a power of two, 1..8.
- SHAMT_W, $clog2(XLEN), derived shift-amount width; not to be overridden.

- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  the operation on funct3/alt/operand_a/operand_b is valid.
- in_ready  out  1  the unit can accept an operation.
- funct3  in  3  operation select.
- alt  in  1  funct7[5]; selects SUB (funct3=0) or SRA (funct3=5); ignored for other funct3 values.
- operand_a  in  XLEN  rs1 value.
- operand_b  in  XLEN  rs2 value; low SHAMT_W bits are the shift amount.
- out_valid  out  1  result is valid.
- out_ready  in  1  the consumer takes the result.
- result  out  XLEN  operation result.
- busy  out  1  an operation is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) & reset_n.
- Accept when in_valid & in_ready. funct3, alt and both operands are captured at accept. Later input changes have no effect. Inputs are ignored when in_ready=0.
- funct3 encodings:
  - 0: ADD, or SUB when alt=1; wraps modulo 2^XLEN.
  - 1: SLL.
  - 2: SLT, signed compare.
  - 3: SLTU, unsigned compare.
  - 4: XOR.
  - 5: SRL, or SRA when alt=1.
  - 6: OR.
  - 7: AND.
- SLT and SLTU results are zero-extended 0 or 1.
- Non-shift ops: result is computed at accept and the FSM goes IDLE->DONE.
- Shift with shamt==0: result=operand_a, IDLE->DONE.
- Shift with shamt>0: IDLE->SHIFT, and a remaining counter is loaded with shamt. Each SHIFT cycle:
  - the working register shifts by min(SHIFT_STEP, remaining);
  - remaining decrements by the same amount;
  - SRA fills with the captured sign bit; SLL and SRL fill with 0.
  - When remaining reaches 0, SHIFT->DONE.
- DONE: out_valid=1 and result is stable. On out_ready=1 the FSM returns to IDLE on the next edge. With out_ready=0 it holds indefinitely.
- result keeps its last value in IDLE. It is never tri-stated.

## Timing
- Reset values (reset_n=0 at a rising edge): state=IDLE, out_valid=0, result=0, busy=0, remaining=0. in_ready is 0 while reset_n=0.
- Reset mid-operation, in SHIFT or DONE: the operation is discarded and no out_valid is produced. The unit is IDLE the cycle after reset_n rises.
- Latency is counted from the accept edge to the first cycle out_valid=1:
  - non-shift ops, or a shift with shamt=0: 1 cycle;
  - shifts: 1 + ceil(shamt/SHIFT_STEP) cycles.
- Throughput: at most one accept per 2 cycles, since in_ready is low in DONE. There is no accept in the same cycle as a result handoff.
- out_valid may depend only on registered state, never combinationally on out_ready.
- Back-to-back: after out_valid & out_ready, in_ready=1 in the following cycle.

## Test plan
- ADD, XLEN=32: a=0xFFFFFFFF, b=1 -> result=0x00000000, out_valid one cycle after accept. SUB (alt=1): a=5, b=7 -> 0xFFFFFFFE.
- Compares: a=0xFFFFFFFF, b=1. SLT -> 1; SLTU -> 0. Same compares with alt=1 give the same results.
- SRA, SHIFT_STEP=1: a=0x80000000, b=31 -> 0xFFFFFFFF, out_valid exactly 32 cycles after accept, busy high throughout. SRL with the same operands -> 0x00000001. With SHIFT_STEP=8 and shamt=31, latency is 5 cycles.
- Shift by zero: SLL with a=0x1234, b=0x20 (shamt bits=0) -> 0x1234 after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle the inputs -> result is stable, in_ready=0, out_valid=1. Raise out_ready -> IDLE and in_ready=1 on the next cycle.
- Reset mid-shift: assert reset_n=0 during SHIFT -> no out_valid, result=0, busy=0. A new op accepted after reset completes correctly.

Source files
------------

// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle_if
//  Description : Handshake bundle between the issue stage and the multi-cycle
//                RV32I ALU. The master side offers operations and takes
//                results. The slave side is the execution unit.
//  Signals     : in_valid/in_ready    - operation handshake
//                funct3/alt           - operation select (alt = funct7[5])
//                operand_a/operand_b  - rs1 / rs2 values
//                out_valid/out_ready  - result handshake
//                result               - operation result
//                busy                 - an operation is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_multicycle_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, alt, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, alt, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Handshake-driven RV32I register-register ALU. Non-shift ops
//                finish in one cycle. Shifts iterate through a narrow shifter,
//                SHIFT_STEP bits per cycle. Each accepted op yields exactly one
//                result, which is held until the consumer takes it.
//  Ports       : clock   - rising-edge clock
//                reset_n - synchronous active-low reset
//                bus     - alu_multicycle_if.slave (handshake, operands, result)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic              clock,
  input  logic              reset_n,
  alu_multicycle_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The per-cycle shift amount never exceeds SHIFT_STEP. Keeping the shifter
  // amount this narrow is what makes the iterative shifter cheap.
  localparam int                 STEP_W   = $clog2(SHIFT_STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(SHIFT_STEP);

  logic [1:0]         state;
  logic [XLEN-1:0]    work;
  logic [XLEN-1:0]    result_q;
  logic [SHAMT_W-1:0] remaining;
  logic               shift_left;
  logic               fill_bit;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [XLEN-1:0]    fast_result;
  logic [SHAMT_W-1:0] step;
  logic [STEP_W-1:0]  step_n;
  logic [XLEN-1:0]    shifted;

  assign bus.in_ready  = (state == ST_IDLE) & reset_n;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.result    = result_q;

  assign shamt    = bus.operand_b[SHAMT_W-1:0];
  assign is_shift = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd5);

  // Single-cycle ops. Shift encodings fall to the default, which returns
  // operand_a. That is the correct result when the shift amount is zero.
  always_comb begin
    fast_result = bus.operand_a;
    case (bus.funct3)
      3'd0: fast_result = bus.alt ? (bus.operand_a - bus.operand_b)
                                  : (bus.operand_a + bus.operand_b);
      3'd2: fast_result = {{(XLEN-1){1'b0}},
                           ($signed(bus.operand_a) < $signed(bus.operand_b))};
      3'd3: fast_result = {{(XLEN-1){1'b0}}, (bus.operand_a < bus.operand_b)};
      3'd4: fast_result = bus.operand_a ^ bus.operand_b;
      3'd6: fast_result = bus.operand_a | bus.operand_b;
      3'd7: fast_result = bus.operand_a & bus.operand_b;
      default: fast_result = bus.operand_a;
    endcase
  end

  // One shifter iteration: shift by min(SHIFT_STEP, remaining). For right
  // shifts, the vacated top bits take the captured fill bit.
  always_comb begin
    step    = (remaining < STEP_AMT) ? remaining : STEP_AMT;
    step_n  = step[STEP_W-1:0];
    shifted = work << step_n;
    if (!shift_left) begin
      shifted = (work >> step_n) |
                (~({XLEN{1'b1}} >> step_n) & {XLEN{fill_bit}});
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      result_q   <= '0;
      remaining  <= '0;
      work       <= '0;
      shift_left <= 1'b0;
      fill_bit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (is_shift && (shamt != '0)) begin
              work       <= bus.operand_a;
              remaining  <= shamt;
              shift_left <= (bus.funct3 == 3'd1);
              fill_bit   <= (bus.funct3 == 3'd5) & bus.alt &
                            bus.operand_a[XLEN-1];
              state      <= ST_SHIFT;
            end else begin
              result_q <= fast_result;
              state    <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          work      <= shifted;
          remaining <= remaining - step;
          // The final step publishes the result directly. DONE then presents
          // it without an extra copy cycle.
          if (remaining == step) begin
            result_q <= shifted;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
